sample_fifo: RTL

Single-clock sample buffer between the voice stage (oscillator × envelope product) and the PDM output stage. The producer pushes amplitude samples with a valid/ready handshake. The consumer pops one sample per sample-rate strobe. On underrun the output holds the last sample, so the PDM modulator never sees a discontinuity.

---
 rtl/sample_fifo_pkg.sv | 13 +
 rtl/sample_fifo_ptr.sv | 33 +++
 rtl/sample_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared types for the voice-to-PDM sample buffer.
package sample_fifo_pkg;

    localparam int AMPLITUDE_BITS = 24;

    typedef logic [AMPLITUDE_BITS-1:0] amplitude;

    // Occupancy needs one bit more than the address so that full and empty differ.
    function automatic int level_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo_ptr.sv
// FIFO pointer register: one extra MSB, wraps naturally modulo 2*DEPTH.
module fifo_ptr
    import sample_fifo_pkg::*;
#(
    parameter int PTR_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sample_fifo.sv
// Sample buffer between voice stage and PDM output; holds last sample on underrun.
// Optional SAMPLE_FIFO_STATS_EN adds underrun_count and max_level outputs.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter int WIDTH     = AMPLITUDE_BITS,
    parameter int DEPTH     = 16,
    parameter int LOW_MARK  = 4,
    parameter int HIGH_MARK = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   rd_tick,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_empty,
    output logic                   almost_full,
`ifdef SAMPLE_FIFO_STATS_EN
    output logic                   underrun,
    output logic [15:0]            underrun_count,
    output logic [$clog2(DEPTH):0] max_level
`else
    output logic                   underrun
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_bits(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_L   = LW'(LOW_MARK);
    localparam logic [LW-1:0] HIGH_L  = LW'(HIGH_MARK);

    if (!(LOW_MARK < HIGH_MARK && HIGH_MARK <= DEPTH)) begin : g_bad_marks
        $error("sample_fifo: need LOW_MARK < HIGH_MARK <= DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic             empty_tick;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             underrun_q, underrun_d;

    assign level        = wr_ptr - rd_ptr;
    assign wr_ready     = (level != DEPTH_L);
    assign almost_empty = (level <= LOW_L);
    assign almost_full  = (level >= HIGH_L);
    assign wr_en        = wr_valid && wr_ready;
    assign rd_en        = rd_tick && (level != '0);
    assign empty_tick   = rd_tick && (level == '0);

    fifo_ptr #(.PTR_W(LW)) u_wr_ptr (
        .clk_i   (clock),
        .rst_n_i (reset),
        .inc_i   (wr_en),
        .ptr_o   (wr_ptr)
    );

    fifo_ptr #(.PTR_W(LW)) u_rd_ptr (
        .clk_i   (clock),
        .rst_n_i (reset),
        .inc_i   (rd_en),
        .ptr_o   (rd_ptr)
    );

    // Storage is never cleared; reset only discards it by zeroing the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        underrun_d = empty_tick;
        if (rd_en) begin
            rd_data_d  = mem_q[rd_ptr[AW-1:0]];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign underrun = underrun_q;

`ifdef SAMPLE_FIFO_STATS_EN
    logic [15:0]   ucnt_q, ucnt_d;
    logic [LW-1:0] max_q, max_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (empty_tick && ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
        end
        max_d = (level > max_q) ? level : max_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ucnt_q <= '0;
            max_q  <= '0;
        end else begin
            ucnt_q <= ucnt_d;
            max_q  <= max_d;
        end
    end

    assign underrun_count = ucnt_q;
    assign max_level      = max_q;
`endif

endmodule
